hyperbus_phy_arbiter: RTL and testbench

- Shares the HyperBus PHYs among NumReq bus-side requesters (cluster DMA ports, host), per-PHY round-robin.
- Each PHY is locked to one owner from grant until the PHY reports transaction end.
- Each PHY is then held idle for a programmable chip-select-high gap (tCSHI) before the next grant.
- Sits between the chimera memory-island/AXI demux and the HyperBus PHY front-ends.

---
 rtl/hyperbus_phy_arbiter_pkg.sv | 22 ++
 rtl/hyperbus_phy_arbiter_if.sv | 29 ++
 rtl/hyperbus_phy_arb_slice.sv | 148 ++++++++++++++
 rtl/hyperbus_phy_arbiter_checker.sv | 44 ++++
 rtl/hyperbus_phy_arbiter.sv | 64 ++++++
 tb/tb_hyperbus_phy_arbiter.sv | 271 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/hyperbus_phy_arbiter_pkg.sv
// Shared HyperBus constants, index widths and the per-PHY arbitration state type.
// Both the arbiter RTL and its bench import this package.
package chimera_hyp_pkg;

    localparam int unsigned NumPhys  = 2;
    localparam int unsigned NumChips = 2;
    localparam int unsigned NumReq   = 4;
    localparam int unsigned GapW     = 4;
    localparam int unsigned PhySelW  = (NumPhys > 1) ? $clog2(NumPhys) : 1;
    localparam int unsigned ReqIdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } phy_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/hyperbus_phy_arbiter_if.sv
// Requester/PHY-side bundle of the HyperBus PHY arbiter.
// The master side drives requests and PHY done pulses; the slave side is the arbiter.
interface hyperbus_phy_arbiter_if #(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned NumPhys = 2,
    parameter int unsigned GapW    = 4
);
    localparam int unsigned PhySelW = (NumPhys > 1) ? $clog2(NumPhys) : 1;
    localparam int unsigned ReqIdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]          req_i;
    logic [NumReq*PhySelW-1:0]  phy_sel_i;
    logic [NumPhys-1:0]         done_i;
    logic [GapW-1:0]            cfg_cs_gap_i;
    logic [NumReq-1:0]          gnt_o;
    logic [NumPhys-1:0]         phy_busy_o;
    logic [NumPhys*ReqIdxW-1:0] phy_owner_o;

    modport master (
        output req_i, phy_sel_i, done_i, cfg_cs_gap_i,
        input  gnt_o, phy_busy_o, phy_owner_o
    );

    modport slave (
        input  req_i, phy_sel_i, done_i, cfg_cs_gap_i,
        output gnt_o, phy_busy_o, phy_owner_o
    );

endinterface

// File: rtl/hyperbus_phy_arb_slice.sv
// One PHY's arbitration slice: IDLE/BUSY/GAP FSM, round-robin pointer,
// chip-select-high gap counter and registered owner/grant.
module hyperbus_phy_arb_slice
    import chimera_hyp_pkg::*;
#(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned NumPhys = 2,
    parameter int unsigned GapW    = 4,
    parameter int unsigned PhyIdx  = 0
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic [NumReq-1:0]                                     req,
    input  logic [NumReq*((NumPhys > 1) ? $clog2(NumPhys) : 1)-1:0] phy_sel,
    input  logic [NumReq-1:0]                                     owned,
    input  logic                                                  done,
    input  logic [GapW-1:0]                                       cfg_cs_gap,
    output logic [NumReq-1:0]                                     gnt,
    output logic                                                  busy,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0]        owner
);
    localparam int unsigned SelW = (NumPhys > 1) ? $clog2(NumPhys) : 1;
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    phy_state_e        state_r, state_nxt_s;
    logic [GapW-1:0]   cnt_r, cnt_nxt_s;
    logic [IdxW-1:0]   ptr_r, ptr_nxt_s;
    logic [IdxW-1:0]   owner_r, owner_nxt_s;
    logic [NumReq-1:0] gnt_r, gnt_nxt_s;
    logic              busy_r;
    logic [NumReq-1:0] eligible_s;
    logic [IdxW-1:0]   next_ptr_s, base_s, winner_s;
    logic              found_s, take_s;
    int unsigned       idx_v;

    // Requesters targeting this PHY that do not already hold a PHY.
    always_comb begin
        eligible_s = {NumReq{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            eligible_s[i] = req[i] && !owned[i] &&
                            (int'(phy_sel[i*SelW +: SelW]) == int'(PhyIdx));
        end
    end

    // Round-robin search; on a done cycle the search already starts past the releasing owner.
    always_comb begin
        next_ptr_s = IdxW'(wrap_inc(32'(owner_r), NumReq));
        base_s     = (state_r == BUSY) ? next_ptr_s : ptr_r;
        found_s    = 1'b0;
        winner_s   = {IdxW{1'b0}};
        idx_v      = 32'd0;
        for (int k = 0; k < NumReq; k++) begin
            idx_v = (32'(base_s) + 32'(k)) % NumReq;
            if (!found_s && eligible_s[idx_v]) begin
                found_s  = 1'b1;
                winner_s = IdxW'(idx_v);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state, gap counter, pointer and grant computation.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        gnt_nxt_s   = gnt_r;
        take_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    take_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (done) begin
                    gnt_nxt_s = {NumReq{1'b0}};
                    ptr_nxt_s = next_ptr_s;
                    if (cfg_cs_gap == {GapW{1'b0}}) begin
                        if (found_s) begin
                            take_s = 1'b1;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        state_nxt_s = GAP;
                        cnt_nxt_s   = cfg_cs_gap;
                    end
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            GAP: begin
                // The last gap cycle doubles as the idle arbitration slot.
                if (cnt_r <= GapW'(1)) begin
                    cnt_nxt_s = {GapW{1'b0}};
                    if (found_s) begin
                        take_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - GapW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {GapW{1'b0}};
                gnt_nxt_s   = {NumReq{1'b0}};
            end
        endcase
        if (take_s) begin
            state_nxt_s = BUSY;
            owner_nxt_s = winner_s;
            gnt_nxt_s   = NumReq'(1) << winner_s;
        end else begin
            owner_nxt_s = owner_nxt_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= {GapW{1'b0}};
            ptr_r   <= {IdxW{1'b0}};
            owner_r <= {IdxW{1'b0}};
            gnt_r   <= {NumReq{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            owner_r <= owner_nxt_s;
            gnt_r   <= gnt_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign gnt   = gnt_r;
    assign busy  = busy_r;
    assign owner = owner_r;

endmodule

// File: rtl/hyperbus_phy_arbiter_checker.sv
// Simulation guards: a requester is held by at most one PHY, and a request
// whose PHY select is out of range is never granted.
module hyperbus_phy_arbiter_checker #(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned NumPhys = 2,
    parameter int unsigned SelW    = 1
) (
    input logic                      clk_i,
    input logic                      rst_i,
    input logic [NumReq-1:0]         req,
    input logic [NumReq*SelW-1:0]    phy_sel,
    input logic [NumPhys*NumReq-1:0] slice_gnt
);
    logic [NumReq-1:0] gnt_s;

    // Merge per-PHY grants into one vector.
    always_comb begin
        gnt_s = {NumReq{1'b0}};
        for (int p = 0; p < NumPhys; p++) begin
            gnt_s = gnt_s | slice_gnt[p*NumReq +: NumReq];
        end
    end

    for (genvar i = 0; i < NumReq; i++) begin : g_req
        logic [NumPhys-1:0] holders_s;
        logic               bad_sel_s;

        // Which PHYs currently grant requester i.
        always_comb begin
            holders_s = {NumPhys{1'b0}};
            for (int p = 0; p < NumPhys; p++) begin
                holders_s[p] = slice_gnt[p*NumReq + i];
            end
        end

        assign bad_sel_s = (int'(phy_sel[i*SelW +: SelW]) >= int'(NumPhys));

        a_single_owner : assert property (@(posedge clk_i) disable iff (rst_i)
            $onehot0(holders_s));
        a_bad_sel_no_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
            (req[i] && !gnt_s[i] && bad_sel_s) |=> !gnt_s[i]);
    end

endmodule

// File: rtl/hyperbus_phy_arbiter.sv
// Shares NumPhys HyperBus PHYs among NumReq requesters, one arbitration slice per PHY.
// A requester holding any PHY is masked out of every slice until released.
module hyperbus_phy_arbiter #(
    parameter int unsigned NumReq  = chimera_hyp_pkg::NumReq,
    parameter int unsigned NumPhys = chimera_hyp_pkg::NumPhys,
    parameter int unsigned GapW    = chimera_hyp_pkg::GapW
) (
    input logic                  clk_i,
    input logic                  rst_i,
    hyperbus_phy_arbiter_if.slave bus
);
    localparam int unsigned SelW = (NumPhys > 1) ? $clog2(NumPhys) : 1;
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumPhys*NumReq-1:0] slice_gnt_s;
    logic [NumPhys-1:0]        busy_s;
    logic [NumPhys*IdxW-1:0]   owner_s;
    logic [NumReq-1:0]         gnt_s;

    for (genvar p = 0; p < NumPhys; p++) begin : g_phy
        hyperbus_phy_arb_slice #(
            .NumReq  (NumReq),
            .NumPhys (NumPhys),
            .GapW    (GapW),
            .PhyIdx  (p)
        ) u_slice (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .req        (bus.req_i),
            .phy_sel    (bus.phy_sel_i),
            .owned      (gnt_s),
            .done       (bus.done_i[p]),
            .cfg_cs_gap (bus.cfg_cs_gap_i),
            .gnt        (slice_gnt_s[p*NumReq +: NumReq]),
            .busy       (busy_s[p]),
            .owner      (owner_s[p*IdxW +: IdxW])
        );
    end

    // OR of registered slice grants; also serves as the "already owns a PHY" mask.
    always_comb begin
        gnt_s = {NumReq{1'b0}};
        for (int p = 0; p < NumPhys; p++) begin
            gnt_s = gnt_s | slice_gnt_s[p*NumReq +: NumReq];
        end
    end

    assign bus.gnt_o       = gnt_s;
    assign bus.phy_busy_o  = busy_s;
    assign bus.phy_owner_o = owner_s;

    hyperbus_phy_arbiter_checker #(
        .NumReq  (NumReq),
        .NumPhys (NumPhys),
        .SelW    (SelW)
    ) u_checker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (bus.req_i),
        .phy_sel   (bus.phy_sel_i),
        .slice_gnt (slice_gnt_s)
    );

endmodule

// File: tb/tb_hyperbus_phy_arbiter.sv
// Bench for hyperbus_phy_arbiter: expected grants (requester, cycle) are queued
// as stimulus is driven and popped when a grant bit rises.
module tb_hyperbus_phy_arbiter;
    import chimera_hyp_pkg::*;

    typedef struct {
        int req;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hyperbus_phy_arbiter_if #(.NumReq(NumReq), .NumPhys(NumPhys), .GapW(GapW)) bus ();

    hyperbus_phy_arbiter #(
        .NumReq  (NumReq),
        .NumPhys (NumPhys),
        .GapW    (GapW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check_value(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_gnt(input int r, input int delay);
        exp_t e;
        e.req = r;
        e.cyc = cyc + delay;
        sb_q.push_back(e);
    endtask

    task automatic set_sel(input int r, input int p);
        bus.phy_sel_i[r*PhySelW +: PhySelW] = PhySelW'(p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_i  = '0;
        bus.done_i = '0;
        tick(2);
        rst = 1'b0;
    endtask

    function automatic int owner_of(input int p);
        return int'(bus.phy_owner_o[p*ReqIdxW +: ReqIdxW]);
    endfunction

    // Grant monitor: every rising gnt_o bit must match the head of the scoreboard.
    initial begin
        logic [NumReq-1:0] prev_gnt;
        exp_t e;
        prev_gnt = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NumReq; i++) begin
                if (bus.gnt_o[i] && !prev_gnt[i]) begin
                    if (sb_q.size() == 0) begin
                        check_value("sb_unexpected_gnt", i, -1);
                    end else begin
                        e = sb_q.pop_front();
                        check_value("sb_gnt_req", i, e.req);
                        check_value("sb_gnt_cycle", cyc, e.cyc);
                    end
                end
            end
            prev_gnt = bus.gnt_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_i        = '0;
        bus.phy_sel_i    = '0;
        bus.done_i       = '0;
        bus.cfg_cs_gap_i = '0;
        rst              = 1'b1;
        tick(2);

        // Reset values
        check_value("rst_gnt", int'(bus.gnt_o), 0);
        check_value("rst_busy", int'(bus.phy_busy_o), 0);
        check_value("rst_owner", int'(bus.phy_owner_o), 0);
        rst = 1'b0;
        tick();

        // Single request on a free PHY: one-cycle latency
        set_sel(0, 0);
        bus.req_i = 4'b0001;
        expect_gnt(0, 1);
        tick();
        check_value("t1_gnt", int'(bus.gnt_o), 1);
        check_value("t1_busy", int'(bus.phy_busy_o), 1);
        check_value("t1_owner", owner_of(0), 0);
        bus.req_i  = 4'b0000;
        bus.done_i = 2'b01;
        tick();
        bus.done_i = 2'b00;
        check_value("t1_release_gnt", int'(bus.gnt_o), 0);
        check_value("t1_release_busy", int'(bus.phy_busy_o), 0);

        // Round-robin fairness: all four on PHY0, no gap
        do_reset();
        bus.cfg_cs_gap_i = 4'd0;
        for (int i = 0; i < NumReq; i++) set_sel(i, 0);
        bus.req_i = 4'b1111;
        expect_gnt(0, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            check_value("rr_owner", owner_of(0), k % 4);
            check_value("rr_gnt", int'(bus.gnt_o), 1 << (k % 4));
            tick();
            check_value("rr_hold", int'(bus.gnt_o), 1 << (k % 4));
            bus.done_i = 2'b01;
            if (k < 4) begin
                expect_gnt((k + 1) % 4, 1);
            end else begin
                bus.req_i = 4'b0000;
            end
            tick();
            bus.done_i = 2'b00;
        end
        check_value("rr_end_gnt", int'(bus.gnt_o), 0);
        check_value("rr_end_busy", int'(bus.phy_busy_o), 0);

        // CS-high gap of 3 with a pending requester
        bus.cfg_cs_gap_i = 4'd3;
        set_sel(0, 0);
        set_sel(1, 0);
        bus.req_i = 4'b0001;
        expect_gnt(0, 1);
        tick();
        bus.done_i = 2'b01;
        bus.req_i  = 4'b0010;
        expect_gnt(1, 4);
        tick();
        bus.done_i = 2'b00;
        for (int j = 1; j <= 3; j++) begin
            check_value("gap_gnt", int'(bus.gnt_o), 0);
            check_value("gap_busy", int'(bus.phy_busy_o), 1);
            tick();
        end
        check_value("gap_next_gnt", int'(bus.gnt_o), 2);
        check_value("gap_next_owner", owner_of(0), 1);
        bus.done_i = 2'b01;
        bus.req_i  = 4'b0000;
        tick();
        bus.done_i = 2'b00;
        check_value("gap2_busy", int'(bus.phy_busy_o), 1);
        tick(3);
        check_value("gap2_idle", int'(bus.phy_busy_o), 0);

        // Two PHYs granted in the same cycle, released independently
        bus.cfg_cs_gap_i = 4'd0;
        set_sel(0, 0);
        set_sel(1, 1);
        bus.req_i = 4'b0011;
        expect_gnt(0, 1);
        expect_gnt(1, 1);
        tick();
        check_value("dual_gnt", int'(bus.gnt_o), 3);
        check_value("dual_busy", int'(bus.phy_busy_o), 3);
        check_value("dual_owner0", owner_of(0), 0);
        check_value("dual_owner1", owner_of(1), 1);
        bus.done_i = 2'b10;
        bus.req_i  = 4'b0001;
        tick();
        bus.done_i = 2'b00;
        check_value("dual_rel1_gnt", int'(bus.gnt_o), 1);
        check_value("dual_rel1_busy", int'(bus.phy_busy_o), 1);
        bus.done_i = 2'b01;
        bus.req_i  = 4'b0000;
        tick();
        bus.done_i = 2'b00;
        check_value("dual_rel0_gnt", int'(bus.gnt_o), 0);
        check_value("dual_rel0_busy", int'(bus.phy_busy_o), 0);

        // Done on an idle PHY and a request withdrawn before it is granted
        set_sel(0, 0);
        set_sel(2, 0);
        bus.req_i = 4'b0001;
        expect_gnt(0, 1);
        tick();
        bus.req_i = 4'b0101;
        tick();
        bus.done_i = 2'b10;
        tick();
        bus.done_i = 2'b00;
        check_value("idle_done_busy", int'(bus.phy_busy_o), 1);
        check_value("idle_done_gnt", int'(bus.gnt_o), 1);
        bus.req_i = 4'b0001;
        tick();
        bus.done_i = 2'b01;
        bus.req_i  = 4'b0000;
        tick();
        bus.done_i = 2'b00;
        check_value("withdraw_gnt", int'(bus.gnt_o), 0);
        tick(2);
        check_value("withdraw_gnt_late", int'(bus.gnt_o), 0);
        check_value("withdraw_busy", int'(bus.phy_busy_o), 0);

        // Asynchronous reset while PHY0 is busy and PHY1 is counting its gap
        bus.cfg_cs_gap_i = 4'd3;
        set_sel(0, 0);
        set_sel(1, 1);
        bus.req_i = 4'b0011;
        expect_gnt(0, 1);
        expect_gnt(1, 1);
        tick();
        bus.done_i = 2'b10;
        bus.req_i  = 4'b0001;
        tick();
        bus.done_i = 2'b00;
        check_value("prerst_busy", int'(bus.phy_busy_o), 3);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check_value("async_rst_gnt", int'(bus.gnt_o), 0);
        check_value("async_rst_busy", int'(bus.phy_busy_o), 0);
        check_value("async_rst_owner", int'(bus.phy_owner_o), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NumReq; i++) set_sel(i, 0);
        bus.req_i = 4'b1111;
        expect_gnt(0, 1);
        tick();
        check_value("postrst_owner", owner_of(0), 0);
        check_value("postrst_gnt", int'(bus.gnt_o), 1);
        bus.done_i = 2'b01;
        bus.req_i  = 4'b0000;
        tick();
        bus.done_i = 2'b00;
        tick(4);
        check_value("postrst_idle", int'(bus.phy_busy_o), 0);

        check_value("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
